// File: rtl/prog_memory_pkg.sv
// Shared definitions for the program memory: FSM state encoding and the NOP word.
package prog_memory_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Sliced to DATA_W at the point of use.
    localparam logic [255:0] NOP_WORD = '0;

endpackage

// File: rtl/prog_memory_array.sv
// Single-port word array: synchronous write, combinational read, no reset on contents.
module prog_memory_array
    import prog_memory_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_memory.sv
// Loadable program memory with LOAD/RUN FSM and 1-cycle registered fetch.
// Optional macro PROG_MEMORY_PARITY_EN adds a stored even-parity bit and a par_err output.
module prog_memory
    import prog_memory_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          inAddr,
    input  logic                       fetch_en,
    output logic [DATA_W-1:0]          outData,
    output logic                       out_valid,
    output logic                       addr_err,
    input  logic                       ld_start,
    input  logic                       ld_valid,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       ld_ready,
    input  logic                       ld_done,
    output logic [$clog2(DEPTH):0]     ld_count,
    output logic                       ld_ovf,
`ifdef PROG_MEMORY_PARITY_EN
    output logic                       par_err,
`endif
    output logic                       run_mode
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
`ifdef PROG_MEMORY_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_W + PAR_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t state, state_next;

    logic              wr_en;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic [CMP_W-1:0]  addr_ext;
    logic [CMP_W-1:0]  cnt_ext;
    logic              in_range;

    assign ld_ready = (state == LOAD) && (ld_count < DEPTH_C);
    assign run_mode = (state == RUN);
    // Reset and a restart both discard the word offered in the same cycle.
    assign wr_en    = !rst && !ld_start && (state == LOAD) && ld_valid && ld_ready;

`ifdef PROG_MEMORY_PARITY_EN
    assign wr_word = {^ld_data, ld_data};
`else
    assign wr_word = ld_data;
`endif

    assign addr_ext = CMP_W'(inAddr);
    assign cnt_ext  = CMP_W'(ld_count);
    assign in_range = addr_ext < cnt_ext;

    prog_memory_array #(
        .WIDTH(WORD_W),
        .DEPTH(DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (wr_en),
        .waddr(ld_count[AW-1:0]),
        .wdata(wr_word),
        .raddr(addr_ext[AW-1:0]),
        .rdata(rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // ld_start takes priority over ld_done in either state.
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (!ld_start && ld_done) state_next = RUN;
            RUN:     if (ld_start)             state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || ld_start) begin
            ld_count <= '0;
            ld_ovf   <= 1'b0;
        end else if (state == LOAD && ld_valid) begin
            if (ld_ready) begin
                ld_count <= ld_count + CNT_W'(1);
            end else begin
                ld_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_next == LOAD) begin
            outData   <= NOP_WORD[DATA_W-1:0];
            out_valid <= 1'b0;
            addr_err  <= 1'b0;
`ifdef PROG_MEMORY_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else if (state == RUN && fetch_en) begin
            if (!in_range) begin
                outData   <= NOP_WORD[DATA_W-1:0];
                out_valid <= 1'b0;
                addr_err  <= 1'b1;
`ifdef PROG_MEMORY_PARITY_EN
                par_err   <= 1'b0;
`endif
            end else begin
`ifdef PROG_MEMORY_PARITY_EN
                // Stored word plus parity bit must XOR to zero.
                if (^rd_word) begin
                    outData   <= NOP_WORD[DATA_W-1:0];
                    out_valid <= 1'b0;
                    par_err   <= 1'b1;
                end else begin
                    outData   <= rd_word[DATA_W-1:0];
                    out_valid <= 1'b1;
                    par_err   <= 1'b0;
                end
`else
                outData   <= rd_word[DATA_W-1:0];
                out_valid <= 1'b1;
`endif
                addr_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_memory.sv
// Directed bench for prog_memory (DEPTH = 4): load/run, out-of-range fetch, overflow,
// stall, reload, simultaneous control pulses, reset mid-load and optional parity.
module tb_prog_memory;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] inAddr;
    logic              fetch_en;
    logic [DATA_W-1:0] outData;
    logic              out_valid;
    logic              addr_err;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic [2:0]        ld_count;
    logic              ld_ovf;
    logic              run_mode;
`ifdef PROG_MEMORY_PARITY_EN
    logic              par_err;
`endif

    int checks = 0;
    int errors = 0;

    prog_memory #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inAddr   (inAddr),
        .fetch_en (fetch_en),
        .outData  (outData),
        .out_valid(out_valid),
        .addr_err (addr_err),
        .ld_start (ld_start),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
        .ld_count (ld_count),
        .ld_ovf   (ld_ovf),
`ifdef PROG_MEMORY_PARITY_EN
        .par_err  (par_err),
`endif
        .run_mode (run_mode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [DATA_W-1:0] w);
        ld_valid = 1'b1;
        ld_data  = w;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_done();
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        inAddr   = a;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; inAddr = '0; fetch_en = 1'b0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_run_mode",  run_mode,  0);
        chk("rst_outData",   outData,   0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_addr_err",  addr_err,  0);
        chk("rst_ld_count",  ld_count,  0);
        chk("rst_ld_ovf",    ld_ovf,    0);
        chk("rst_ld_ready",  ld_ready,  1);

        // Load and run
        load_word(32'h11);
        load_word(32'h22);
        load_word(32'h33);
        chk("load3_count", ld_count, 3);
        pulse_done();
        chk("run_mode_after_done", run_mode, 1);
        chk("run_ld_ready", ld_ready, 0);
        fetch(1);
        chk("fetch1_data",  outData,   32'h22);
        chk("fetch1_valid", out_valid, 1);
        chk("fetch1_err",   addr_err,  0);
        chk("fetch1_count", ld_count,  3);

        // Fetch past ld_count
        fetch(3);
        chk("fetch3_data",  outData,   0);
        chk("fetch3_err",   addr_err,  1);
        chk("fetch3_valid", out_valid, 0);
        fetch(1000);
        chk("fetch1000_data", outData,  0);
        chk("fetch1000_err",  addr_err, 1);

        // Stall holds the last fetch; ld_valid in RUN ignored
        fetch(2);
        chk("fetch2_data", outData, 32'h33);
        inAddr = 0; ld_valid = 1'b1; ld_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_data",  outData,   32'h33);
            chk("stall_valid", out_valid, 1);
        end
        ld_valid = 1'b0;
        chk("run_ldvalid_count", ld_count, 3);
        chk("run_ldvalid_ovf",   ld_ovf,   0);

        // Reload
        pulse_start();
        chk("reload_run_mode", run_mode,  0);
        chk("reload_outData",  outData,   0);
        chk("reload_valid",    out_valid, 0);
        chk("reload_count",    ld_count,  0);
        chk("reload_ovf",      ld_ovf,    0);

        // Overflow with DEPTH = 4
        load_word(32'hA0);
        load_word(32'hA1);
        load_word(32'hA2);
        load_word(32'hA3);
        chk("full_ready", ld_ready, 0);
        load_word(32'hA4);
        chk("ovf_count", ld_count, 4);
        chk("ovf_flag",  ld_ovf,   1);
        pulse_done();
        fetch(3);
        chk("ovf_mem3", outData, 32'hA3);
        fetch(4);
        chk("ovf_5th_absent_err",  addr_err, 1);
        chk("ovf_5th_absent_data", outData,  0);
        fetch(0);
        chk("ovf_mem0", outData, 32'hA0);

        // ld_valid together with ld_done on word 2
        pulse_start();
        load_word(32'hB0);
        ld_valid = 1'b1; ld_data = 32'hB1; ld_done = 1'b1;
        tick();
        ld_valid = 1'b0; ld_done = 1'b0;
        chk("vd_run_mode", run_mode, 1);
        chk("vd_count",    ld_count, 2);
        fetch(1);
        chk("vd_word", outData, 32'hB1);

        // ld_start together with ld_done, from RUN and from LOAD
        ld_start = 1'b1; ld_done = 1'b1;
        tick();
        chk("sd_from_run", run_mode, 0);
        tick();
        ld_start = 1'b0; ld_done = 1'b0;
        chk("sd_from_load", run_mode, 0);

        // Reset mid-load discards the offered word
        load_word(32'hC0);
        rst = 1'b1; ld_valid = 1'b1; ld_data = 32'hC1;
        tick();
        rst = 1'b0; ld_valid = 1'b0;
        chk("rst_mid_count",    ld_count, 0);
        chk("rst_mid_run_mode", run_mode, 0);
        pulse_done();
        fetch(0);
        chk("rst_mid_fetch_err", addr_err, 1);

`ifdef PROG_MEMORY_PARITY_EN
        pulse_start();
        load_word(32'hD0);
        load_word(32'hD1);
        pulse_done();
        fetch(1);
        chk("par_clean_err",  par_err, 0);
        chk("par_clean_data", outData, 32'hD1);
        dut.u_array.mem[1] = dut.u_array.mem[1] ^ 33'h1;
        fetch(1);
        chk("par_bad_err",   par_err,   1);
        chk("par_bad_data",  outData,   0);
        chk("par_bad_valid", out_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_memory.md
PROG_MEMORY -- requirements
Module: prog_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64: number of words, a power of two, at least 2.
REQ-003 The block SHALL have parameter ADDR_W, default 32: width of the fetch address (word index).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clk is the only clock and rst is the only reset.
REQ-005 Port clk: input, 1 bit, clock; all state updates occur on its rising edge.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port inAddr: input, ADDR_W bits, fetch word index.
REQ-008 Port fetch_en: input, 1 bit, fetch enable; when low, the pipeline stalls.
REQ-009 Port outData: output, DATA_W bits, registered instruction word.
REQ-010 Port out_valid: output, 1 bit, outData holds a legal fetched word.
REQ-011 Port addr_err: output, 1 bit, the last fetch was at or beyond ld_count.
REQ-012 Port ld_start: input, 1 bit, debug-unit pulse that enters LOAD mode and clears the load pointer.
REQ-013 Port ld_valid: input, 1 bit, debug-unit write strobe.
REQ-014 Port ld_data: input, DATA_W bits, debug-unit write word.
REQ-015 Port ld_ready: output, 1 bit, the memory accepts a load word this cycle.
REQ-016 Port ld_done: input, 1 bit, debug-unit pulse that ends loading and enters RUN mode.
REQ-017 Port ld_count: output, clog2(DEPTH)+1 bits, number of words loaded.
REQ-018 Port ld_ovf: output, 1 bit, sticky flag set when a word was offered while the memory was full.
REQ-019 Port run_mode: output, 1 bit, high in RUN state.

Function
REQ-020 The FSM SHALL have two states: LOAD and RUN.
REQ-021 The FSM SHALL move from LOAD to RUN on ld_done, and from RUN to LOAD on ld_start.
REQ-022 ld_start in LOAD SHALL restart loading: ld_count cleared to 0 and ld_ovf cleared.
REQ-023 ld_ready SHALL equal (state == LOAD) and (ld_count < DEPTH).
REQ-024 A load transfer SHALL occur when ld_valid and ld_ready are both high: ld_data is written to word index ld_count, and ld_count increments by 1.
REQ-025 When ld_valid is high in LOAD with ld_count == DEPTH, the word SHALL be dropped and ld_ovf set; ld_count SHALL NOT wrap.
REQ-026 ld_valid in RUN SHALL be ignored: no write and no flag.
REQ-027 When ld_valid and ld_done are high in the same cycle, the word SHALL be written first and the block SHALL then be in RUN on the next cycle.
REQ-028 When ld_start and ld_done are high in the same cycle, ld_start SHALL win.
REQ-029 Fetch SHALL have a latency of 1 cycle: in RUN with fetch_en high, outData equals mem[inAddr] on the following edge, with out_valid 1 and addr_err 0, provided inAddr < ld_count.
REQ-030 A RUN fetch with inAddr >= ld_count, including any index >= DEPTH, SHALL produce outData = 0 (NOP), out_valid 0 and addr_err 1 for that cycle; there is no address wrap.
REQ-031 With fetch_en low, outData, out_valid and addr_err SHALL hold their values (stall).
REQ-032 In LOAD state, outData SHALL be 0 and out_valid and addr_err SHALL be 0.
REQ-033 A word written and fetched in the same RUN cycle is impossible, because writes occur only in LOAD; there is no read-during-write hazard.

Reset
REQ-034 On rst: state = LOAD, outData = 0, out_valid = 0, addr_err = 0, ld_count = 0, ld_ovf = 0.
REQ-035 Memory array contents SHALL NOT be cleared by rst; they are unreachable because ld_count = 0.
REQ-036 rst mid-load SHALL override all inputs in that cycle, and any word offered in that cycle SHALL be discarded.

Configuration
REQ-037 Macro PROG_MEMORY_PARITY_EN defined: each word SHALL store one extra even-parity bit computed at write time.
REQ-038 With PROG_MEMORY_PARITY_EN defined, output port par_err SHALL be added: it is 1 when the fetched word's parity mismatches, registered with outData, and outData SHALL then be forced to 0 with out_valid 0.
REQ-039 Macro PROG_MEMORY_PARITY_EN undefined: there SHALL be no parity bit, no par_err port, and the array SHALL be DATA_W bits wide.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding (LOAD = 0, RUN = 1) and the NOP word constant (all zeros).
REQ-041 One sub-module, prog_memory_array, SHALL hold a single-port synchronous-write array with combinational read; the FSM, pointer, flags and output register SHALL live in the top module.

Verification
REQ-042 The bench SHALL cover a load-and-run scenario: rst; load 0x11, 0x22, 0x33 then ld_done; fetch inAddr = 1 -> next cycle outData = 0x22, out_valid 1, ld_count 3, run_mode 1.
REQ-043 The bench SHALL cover a fetch past ld_count: after loading 3 words, fetch inAddr = 3, then 1000 -> outData 0, addr_err 1 both times.
REQ-044 The bench SHALL cover overflow: with DEPTH = 4, offer 5 words -> ld_count 4, ld_ovf 1, mem[3] = 4th word, and the 5th word is absent.
REQ-045 The bench SHALL cover stall and reload: fetch_en low for 3 cycles -> outData held; then ld_start -> run_mode 0, outData 0, ld_count 0, ld_ovf 0.
REQ-046 The bench SHALL cover simultaneous events: ld_valid with ld_done on word 2 -> word stored, run_mode 1 next cycle; ld_start with ld_done -> LOAD.
REQ-047 The bench SHALL cover parity, with PROG_MEMORY_PARITY_EN defined: flip a stored data bit through a hierarchical force, then fetch -> par_err 1, outData 0, out_valid 0.
